// File: rtl/alu8_pkg.sv
// alu8_pkg: shared constants for the alu8 pipeline slice.
// Holds the opcode encodings, the signed saturation values and
// default widths used by alu8_core and alu8_pipe_unit.
package alu8_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned OP_W      = 2;
  localparam int unsigned CNT_W_DEF = 16;

  // Opcode encodings carried on in_op / out_op
  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_AND = 2'b10;
  localparam logic [OP_W-1:0] OP_OR  = 2'b11;

  // Signed saturation limits for an 8-bit result
  localparam logic [DATA_W-1:0] SAT_POS = 8'h7F;
  localparam logic [DATA_W-1:0] SAT_NEG = 8'h80;

endpackage : alu8_pkg

// File: rtl/alu8_core.sv
// alu8_core: purely combinational 8-bit ALU datapath.
// Optional build macro: ALU_SAT_EN -- when defined, an ADD/SUB that
// overflows returns the signed limit (SAT_POS / SAT_NEG) instead of the
// wrapped result; carry and ovf are reported unchanged.
// Ports:
//   a, b   in  WIDTH  operands
//   op     in  2      opcode (ADD/SUB/AND/OR)
//   res    out WIDTH  result (saturated when enabled and ovf=1)
//   carry  out 1      ADD carry-out, SUB borrow (a<b), else 0
//   ovf    out 1      signed overflow for ADD/SUB, else 0
module alu8_core
  import alu8_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             ovf
);

  localparam int unsigned MSB = WIDTH - 1;

`ifdef ALU_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [WIDTH:0]   sum_c;
  logic [WIDTH:0]   diff_c;
  logic [WIDTH-1:0] raw_c;
  logic [WIDTH-1:0] sat_c;

  // One extra bit so the top bit is carry-out / borrow directly
  assign sum_c  = {1'b0, a} + {1'b0, b};
  assign diff_c = {1'b0, a} - {1'b0, b};

  // On overflow the true result always has the sign of operand a
  assign sat_c = a[MSB] ? WIDTH'(SAT_NEG) : WIDTH'(SAT_POS);

  // Opcode decode: wrapped result plus flags
  always_comb begin
    raw_c = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        raw_c = sum_c[WIDTH-1:0];
        carry = sum_c[WIDTH];
        ovf   = (a[MSB] == b[MSB]) && (sum_c[MSB] != a[MSB]);
      end
      OP_SUB: begin
        raw_c = diff_c[WIDTH-1:0];
        carry = diff_c[WIDTH];
        ovf   = (a[MSB] != b[MSB]) && (diff_c[MSB] != a[MSB]);
      end
      OP_AND: raw_c = a & b;
      OP_OR:  raw_c = a | b;
      default: raw_c = '0;
    endcase
  end

  assign res = (SAT_EN && ovf) ? sat_c : raw_c;

endmodule : alu8_core

// File: rtl/alu8_pipe_unit.sv
// alu8_pipe_unit: two-stage pipelined 8-bit ALU with valid/ready on both
// sides and full backpressure (one operation per cycle sustained).
// Stage 1 (s1) captures the operand transaction; the output register holds
// the result and flags computed by alu8_core until the consumer takes it.
// Optional build macro: ALU_SAT_EN (signed saturation inside alu8_core).
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    operand handshake (in_ready is combinational)
//   in_a, in_b, in_op    operands and opcode
//   out_valid/out_ready  result handshake
//   out_res, out_carry, out_ovf, out_zero, out_op   registered result
//   op_cnt               count of retired results, wraps
module alu8_pipe_unit
  import alu8_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [1:0]       out_op,
  output logic [CNT_W-1:0] op_cnt
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [1:0]       s1_op;

  logic             s1_adv;
  logic             accept;
  logic             retire;

  logic [WIDTH-1:0] core_res;
  logic             core_carry;
  logic             core_ovf;

  // s1 may move forward whenever the output register is empty or draining
  assign s1_adv   = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s1_adv;
  assign accept   = in_valid & in_ready;
  assign retire   = out_valid & out_ready;

  // Stage 1: operand capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_op    <= in_op;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  alu8_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a     (s1_a),
    .b     (s1_b),
    .op    (s1_op),
    .res   (core_res),
    .carry (core_carry),
    .ovf   (core_ovf)
  );

  // Stage 2: output register, held stable while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
      out_op    <= '0;
    end else if (s1_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_res   <= core_res;
        out_carry <= core_carry;
        out_ovf   <= core_ovf;
        out_zero  <= (core_res == '0);
        out_op    <= s1_op;
      end
    end
  end

  // Retired-result counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_cnt <= '0;
    end else if (retire) begin
      op_cnt <= op_cnt + CNT_W'(1);
    end
  end

endmodule : alu8_pipe_unit
